fetch_queue: RTL

Parametrised instruction fetch queue between instruction memory and the IF/ID stage register. It decouples PC advance from IF/ID load-enable stalls by buffering up to DEPTH fetched {PC, instruction} pairs, and it is flushed on a taken branch or jump. When empty it presents an all-zero (NOP) instruction, so the ID stage sees a bubble. It also keeps a saturating bubble counter for performance monitoring.

---
 rtl/fetch_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {PC, instruction} between imem and IF/ID.
// Define FETCH_QUEUE_BYPASS_EN to pass a word straight through when the queue is empty.
module fetch_queue #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]        in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [DATA_W-1:0]        out_instr,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  L_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [CNT_W-1:0]  r_bubble;
    logic [PC_W-1:0]   r_pc_mem    [DEPTH];
    logic [DATA_W-1:0] r_instr_mem [DEPTH];

    logic w_has_room;
    logic w_head_valid;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_bubble;

    // Everything is gated by reset so the stage sees a quiet interface while held.
    assign w_has_room   = reset && (r_count < L_DEPTH) && !flush;
    assign w_head_valid = reset && (r_count != '0) && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = reset && (r_count == '0) && in_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        in_ready  = w_has_room;
        out_valid = w_head_valid || w_bypass;
        out_pc    = '0;
        out_instr = '0;
        if (w_bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (w_head_valid) begin
            out_pc    = r_pc_mem[r_rd_ptr];
            out_instr = r_instr_mem[r_rd_ptr];
        end
    end

    // A bypassed word taken by ID this cycle never enters storage.
    assign w_push   = in_valid && w_has_room && !(w_bypass && out_ready);
    assign w_pop    = w_head_valid && out_ready;
    assign w_bubble = out_ready && !out_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_bubble <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
            end
            if (w_bubble && (r_bubble != '1))
                r_bubble <= r_bubble + CNT_W'(1);
        end
    end

    // Storage is never cleared; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

    assign count      = r_count;
    assign bubble_cnt = r_bubble;

endmodule
